// File: rtl/mips_core_pkg.sv
`default_nettype none
// mips_core_pkg: shared types and defaults for the mips_core back end.
// Revision 1.0 - multi-port register file additions.
package mips_core_pkg;

   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rf_state_t;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_NUM_REGS   = 64;

endpackage
`default_nettype wire

// File: rtl/rf_write_resolve.sv
`default_nettype none
// rf_write_resolve: finds the winning write port (highest index) for one address.
// Revision 1.0 - initial release.
module rf_write_resolve #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_WRITE  = 2
) (
   input  logic [NUM_WRITE-1:0]            wr_en_i,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0]           addr_i,
   output logic                            hit_o,
   output logic [DATA_WIDTH-1:0]           data_o
);

   // Ascending scan so the last matching (highest) port overrides earlier ones.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      for (int j = 0; j < NUM_WRITE; j++) begin
         if (wr_en_i[j] && (wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == addr_i) &&
             (addr_i != '0)) begin
            hit_o  = 1'b1;
            data_o = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// reg_file_mp: multi-port register file with bypass, pending scoreboard and clear sweep.
// Revision 1.0 - initial release.
module reg_file_mp
   import mips_core_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int NUM_REGS   = RF_NUM_REGS,
   parameter int NUM_READ   = 4,
   parameter int NUM_WRITE  = 2,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                            clk,
   input  logic                            rst,
   output logic                            init_done,
   input  logic [NUM_READ-1:0]             rd_en,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
   output logic [NUM_READ-1:0]             rd_pending,
   input  logic [NUM_WRITE-1:0]            wr_en,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
   input  logic                            rsv_en,
   input  logic [ADDR_WIDTH-1:0]           rsv_addr
);

   rf_state_t               state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    init_done_q;

   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]     pending_q, pending_d;

   logic                    w_ready;
   logic                    w_upd_en;

   assign w_ready   = (state_q == RF_READY);
   assign w_upd_en  = w_ready && !rst;
   assign init_done = init_done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RF_CLEAR: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == ADDR_WIDTH'(NUM_REGS - 1)) begin
               state_d = RF_READY;
            end
         end
         RF_READY: begin
            state_d = RF_READY;
         end
         default: begin
            state_d = RF_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RF_CLEAR;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= (state_d == RF_READY);
      end
   end

   // Per-register next state: sweep clear, then write data, then reserve over write-clear.
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      logic                  w_hit;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_sweep;
      logic                  w_rsv;

      rf_write_resolve #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .NUM_WRITE  (NUM_WRITE)
      ) u_resolve (
         .wr_en_i   (wr_en),
         .wr_addr_i (wr_addr),
         .wr_data_i (wr_data),
         .addr_i    (ADDR_WIDTH'(r)),
         .hit_o     (w_hit),
         .data_o    (w_data)
      );

      assign w_sweep = (state_q == RF_CLEAR) && (cnt_q == ADDR_WIDTH'(r));
      assign w_rsv   = w_upd_en && rsv_en && (rsv_addr == ADDR_WIDTH'(r)) && (r != 0);

      assign regs_d[r]    = w_sweep              ? '0     :
                            (w_upd_en && w_hit)  ? w_data : regs_q[r];
      assign pending_d[r] = w_sweep              ? 1'b0   :
                            w_rsv                ? 1'b1   :
                            (w_upd_en && w_hit)  ? 1'b0   : pending_q[r];
   end

   always_ff @(posedge clk) begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_addr;
      logic                  w_hit;
      logic [DATA_WIDTH-1:0] w_byp;
      logic                  w_act;

      assign w_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_act  = w_ready && rd_en[i] && (w_addr != '0);

      rf_write_resolve #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .NUM_WRITE  (NUM_WRITE)
      ) u_bypass (
         .wr_en_i   (wr_en),
         .wr_addr_i (wr_addr),
         .wr_data_i (wr_data),
         .addr_i    (w_addr),
         .hit_o     (w_hit),
         .data_o    (w_byp)
      );

      assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = !w_act ? '0    :
                                                   w_hit  ? w_byp : regs_q[w_addr];
      assign rd_pending[i] = w_act && !w_hit && pending_q[w_addr];
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// tb_reg_file_mp: directed and randomized checks of reg_file_mp against a behavioural model.
// Revision 1.0 - initial release.
module tb_reg_file_mp;

   localparam int DW  = 32;
   localparam int NR  = 64;
   localparam int NRD = 4;
   localparam int NWR = 2;
   localparam int AW  = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              init_done;
   logic [NRD-1:0]    rd_en;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_pending;
   logic [NWR-1:0]    wr_en;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic              rsv_en;
   logic [AW-1:0]     rsv_addr;

   always #5 clk = ~clk;

   reg_file_mp u_dut (
      .clk        (clk),
      .rst        (rst),
      .init_done  (init_done),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_pending (rd_pending),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr)
   );

   logic [DW-1:0] m_regs [NR];
   bit            m_pend [NR];
   bit            m_clear = 1'b1;
   int            m_cnt   = 0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference read: later write ports override earlier ones for the bypass.
   function automatic void exp_read(input int i, output logic [DW-1:0] d, output bit p);
      int a;
      a = int'(rd_addr[i*AW +: AW]);
      d = '0;
      p = 1'b0;
      if (m_clear || !rd_en[i] || a == 0) return;
      d = m_regs[a];
      p = m_pend[a];
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
            d = wr_data[j*DW +: DW];
            p = 1'b0;
         end
      end
   endfunction

   task automatic check_outputs();
      logic [DW-1:0] d;
      bit            p;
      check("init_done", DW'(init_done), DW'(!m_clear));
      for (int i = 0; i < NRD; i++) begin
         exp_read(i, d, p);
         check($sformatf("rd_data%0d", i), rd_data[i*DW +: DW], d);
         check($sformatf("rd_pending%0d", i), DW'(rd_pending[i]), DW'(p));
      end
   endtask

   task automatic model_edge();
      int a;
      if (rst) begin
         m_clear = 1'b1;
         m_cnt   = 0;
      end else if (m_clear) begin
         m_regs[m_cnt] = '0;
         m_pend[m_cnt] = 1'b0;
         m_cnt++;
         if (m_cnt == NR) m_clear = 1'b0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            a = int'(wr_addr[j*AW +: AW]);
            if (wr_en[j] && a != 0) begin
               m_regs[a] = wr_data[j*DW +: DW];
               m_pend[a] = 1'b0;
            end
         end
         if (rsv_en && rsv_addr != '0) m_pend[int'(rsv_addr)] = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      rst    = 1'b0;
      rd_en  = '0;
      rd_addr = '0;
      wr_en  = '0;
      wr_addr = '0;
      wr_data = '0;
      rsv_en = 1'b0;
      rsv_addr = '0;
   endtask

   task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
      wr_en[p] = 1'b1;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic set_rd(input int p, input int a);
      rd_en[p] = 1'b1;
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   // Runs 64 sweep cycles with junk writes/reserves and returns how many had init_done low.
   task automatic sweep_with_junk(output int low);
      low = 0;
      for (int c = 0; c < NR; c++) begin
         idle();
         set_wr(0, 5, $urandom);
         set_wr(1, int'($urandom_range(1, NR-1)), $urandom);
         rsv_en = 1'b1;
         rsv_addr = AW'($urandom_range(1, NR-1));
         for (int i = 0; i < NRD; i++) set_rd(i, int'($urandom_range(1, NR-1)));
         #1;
         if (!init_done) low++;
         tick();
      end
      idle();
      #1;
   endtask

   initial begin
      int low;
      idle();
      rst = 1'b1;
      @(posedge clk);
      model_edge();
      #1;

      // Reset sweep
      rst = 1'b1;
      tick();
      sweep_with_junk(low);
      check("sweep_len", DW'(low), DW'(NR));
      check("init_done_after_sweep", DW'(init_done), 32'd1);
      set_rd(0, 5);
      #1;
      check("reg5_after_sweep", rd_data[0 +: DW], 32'h0);
      tick();

      // Bypass and store
      idle();
      set_wr(0, 7, 32'hDEADBEEF);
      set_rd(0, 7);
      #1;
      check("bypass7", rd_data[0 +: DW], 32'hDEADBEEF);
      tick();
      idle();
      set_rd(0, 7);
      #1;
      check("stored7", rd_data[0 +: DW], 32'hDEADBEEF);
      tick();

      // Write-port priority
      idle();
      set_wr(0, 3, 32'h11);
      set_wr(1, 3, 32'h22);
      set_rd(1, 3);
      #1;
      check("prio_bypass", rd_data[DW +: DW], 32'h22);
      tick();
      idle();
      set_rd(1, 3);
      #1;
      check("prio_stored", rd_data[DW +: DW], 32'h22);
      tick();

      // Register 0 and read-enable gating
      idle();
      set_wr(0, 0, 32'hFFFF_FFFF);
      set_rd(2, 0);
      #1;
      check("reg0_bypass", rd_data[2*DW +: DW], 32'h0);
      tick();
      idle();
      set_rd(2, 0);
      rd_addr[0 +: AW] = AW'(7);
      #1;
      check("reg0_read", rd_data[2*DW +: DW], 32'h0);
      check("rd_en_gate", rd_data[0 +: DW], 32'h0);
      tick();

      // Scoreboard
      idle();
      rsv_en = 1'b1;
      rsv_addr = AW'(9);
      tick();
      idle();
      set_rd(0, 9);
      #1;
      check("pend9_set", DW'(rd_pending[0]), 32'd1);
      set_wr(1, 9, 32'h5);
      #1;
      check("pend9_bypass", DW'(rd_pending[0]), 32'd0);
      check("data9_bypass", rd_data[0 +: DW], 32'h5);
      tick();
      idle();
      set_rd(0, 9);
      #1;
      check("pend9_cleared", DW'(rd_pending[0]), 32'd0);
      tick();
      idle();
      rsv_en = 1'b1;
      rsv_addr = AW'(9);
      set_wr(0, 9, 32'h77);
      tick();
      idle();
      set_rd(3, 9);
      #1;
      check("rsv_wins_pend", DW'(rd_pending[3]), 32'd1);
      check("rsv_wins_data", rd_data[3*DW +: DW], 32'h77);
      tick();

      // Reset mid-sweep
      idle();
      set_wr(0, 12, 32'hABCD);
      tick();
      idle();
      rst = 1'b1;
      tick();
      idle();
      for (int c = 0; c < 30; c++) tick();
      rst = 1'b1;
      tick();
      sweep_with_junk(low);
      check("midsweep_len", DW'(low), DW'(NR));
      set_rd(0, 12);
      #1;
      check("reg12_cleared", rd_data[0 +: DW], 32'h0);
      tick();

      // Randomized traffic on a narrow address window to force collisions
      for (int c = 0; c < 2000; c++) begin
         idle();
         rst = ($urandom_range(0, 999) == 0);
         rd_en = NRD'($urandom);
         for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
         for (int j = 0; j < NWR; j++) begin
            wr_en[j] = ($urandom_range(0, 2) == 0);
            wr_addr[j*AW +: AW] = AW'($urandom_range(0, 15));
            wr_data[j*DW +: DW] = $urandom;
         end
         rsv_en = ($urandom_range(0, 3) == 0);
         rsv_addr = AW'($urandom_range(0, 15));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
